// File: rtl/merge_stream_ctrl_pkg.sv
// Shared constants for the merge stream controller: state encoding, data width
// and the default FIFO depth and counter width.
package merge_stream_ctrl_pkg;

   localparam int DATA_W    = 32;
   localparam int DEPTH_DEF = 512;
   localparam int CW_DEF    = 11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_A = 3'd1;
   localparam logic [2:0] ST_LOAD_B = 3'd2;
   localparam logic [2:0] ST_MERGE  = 3'd3;
   localparam logic [2:0] ST_RD     = 3'd4;
   localparam logic [2:0] ST_CAPT   = 3'd5;
   localparam logic [2:0] ST_SEND   = 3'd6;

endpackage

// File: rtl/merge_stream_ctrl.sv
// Streams two lists into the merge core's input FIFOs, runs the merge, then
// drains the merged FIFO onto the output stream one word per three cycles.
//
// state   | meaning
// IDLE    | waiting for the first beat of list A (written to FIFO1)
// LOAD_A  | writing list A into FIFO1 until tlast
// LOAD_B  | writing list B into FIFO2 until tlast
// MERGE   | start held high until the core reports done
// RD      | one-cycle read strobe to the merged FIFO
// CAPT    | register merged FIFO dout into the output word
// SEND    | hold output valid until the consumer accepts it
module merge_stream_ctrl
   import merge_stream_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic [DATA_W-1:0] fifoWrData,
   output logic              fifo1WrEn,
   output logic              fifo2WrEn,
   output logic              start,
   input  logic              done,
   output logic              mergedFifoRdEn,
   input  logic [DATA_W-1:0] mergedFifoRdData,
   output logic              busy,
   output logic              overflow
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [2:0]    state;
   logic [CW-1:0] cnt_a;
   logic [CW-1:0] cnt_b;
   logic [CW-1:0] remaining;
   logic          beat;
   logic          in_a;
   logic          in_b;
   logic          full_a;
   logic          full_b;

   assign s_axis_tready = (state == ST_IDLE) || (state == ST_LOAD_A) || (state == ST_LOAD_B);
   // Strobes are gated by reset so an abort produces no further core-side activity.
   assign beat   = s_axis_tvalid & s_axis_tready & ~reset;
   assign in_a   = (state == ST_IDLE) || (state == ST_LOAD_A);
   assign in_b   = (state == ST_LOAD_B);
   assign full_a = (cnt_a >= DEPTH_C);
   assign full_b = (cnt_b >= DEPTH_C);

   assign fifoWrData     = s_axis_tdata;
   assign fifo1WrEn      = beat & in_a & ~full_a;
   assign fifo2WrEn      = beat & in_b & ~full_b;
   assign start          = (state == ST_MERGE) & ~reset;
   assign mergedFifoRdEn = (state == ST_RD) & (remaining != '0) & ~reset;
   assign m_axis_tvalid  = (state == ST_SEND);
   assign busy           = (state != ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt_a        <= '0;
         cnt_b        <= '0;
         remaining    <= '0;
         overflow     <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tlast <= 1'b0;
      end else begin
         if (fifo1WrEn) cnt_a <= cnt_a + ONE_C;
         if (fifo2WrEn) cnt_b <= cnt_b + ONE_C;
         // An over-length beat is swallowed but its tlast still counts.
         if (beat && ((in_a && full_a) || (in_b && full_b))) overflow <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (beat) state <= s_axis_tlast ? ST_LOAD_B : ST_LOAD_A;
            end
            ST_LOAD_A: begin
               if (beat && s_axis_tlast) state <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               if (beat && s_axis_tlast) state <= ST_MERGE;
            end
            ST_MERGE: begin
               remaining <= cnt_a + cnt_b;
               if (done) state <= ST_RD;
            end
            ST_RD: begin
               state <= (remaining != '0) ? ST_CAPT : ST_IDLE;
            end
            ST_CAPT: begin
               m_axis_tdata <= mergedFifoRdData;
               m_axis_tlast <= (remaining == ONE_C);
               state        <= ST_SEND;
            end
            ST_SEND: begin
               if (m_axis_tready) begin
                  remaining <= remaining - ONE_C;
                  if (m_axis_tlast) begin
                     state        <= ST_IDLE;
                     cnt_a        <= '0;
                     cnt_b        <= '0;
                     m_axis_tlast <= 1'b0;
                  end else begin
                     state <= ST_RD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_merge_stream_ctrl.sv
// Directed bench for merge_stream_ctrl with a behavioural merge core and
// merged FIFO; expected output words are written out by hand per scenario.
module tb_merge_stream_ctrl;

   localparam int DEPTH = 16;
   localparam int CW    = 6;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [31:0] fifoWrData;
   logic        fifo1WrEn;
   logic        fifo2WrEn;
   logic        start;
   logic        done;
   logic        mergedFifoRdEn;
   logic [31:0] mergedFifoRdData;
   logic        busy;
   logic        overflow;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [31:0] merged[$];
   logic [31:0] in_q[$];
   logic [31:0] exp_q[$];
   int wr1_cnt = 0;
   int wr2_cnt = 0;
   int rd_underflow = 0;
   int dly = 0;

   always #5 clock = ~clock;

   merge_stream_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clock(clock), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .fifoWrData(fifoWrData), .fifo1WrEn(fifo1WrEn), .fifo2WrEn(fifo2WrEn),
      .start(start), .done(done), .mergedFifoRdEn(mergedFifoRdEn),
      .mergedFifoRdData(mergedFifoRdData), .busy(busy), .overflow(overflow)
   );

   function automatic void build_merge();
      merged.delete();
      while (qa.size() > 0 || qb.size() > 0) begin
         if (qb.size() == 0 || (qa.size() > 0 && qa[0] <= qb[0]))
            merged.push_back(qa.pop_front());
         else
            merged.push_back(qb.pop_front());
      end
   endfunction

   // Merge core and merged FIFO model sharing the controller's reset.
   always @(posedge clock) begin
      if (reset) begin
         qa.delete();
         qb.delete();
         merged.delete();
         done <= 1'b0;
         dly  <= 0;
      end else begin
         if (fifo1WrEn) begin qa.push_back(fifoWrData); wr1_cnt <= wr1_cnt + 1; end
         if (fifo2WrEn) begin qb.push_back(fifoWrData); wr2_cnt <= wr2_cnt + 1; end
         if (mergedFifoRdEn) begin
            if (merged.size() > 0) mergedFifoRdData <= merged.pop_front();
            else rd_underflow <= rd_underflow + 1;
         end
         if (start && !done) begin
            dly <= dly + 1;
            if (dly == 7) begin done <= 1'b1; build_merge(); end
         end else if (!start) begin
            done <= 1'b0;
            dly  <= 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_q();
      for (int i = 0; i < in_q.size(); i++) begin
         @(negedge clock);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = in_q[i];
         s_axis_tlast  = (i == in_q.size() - 1);
      end
      @(negedge clock);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_start();
      int t = 0;
      while (!start && t < 100) begin @(negedge clock); t++; end
      check("start_rise", {31'b0, start}, 32'd1);
   endtask

   task automatic collect(input bit toggle);
      int got = 0;
      int n = exp_q.size();
      int budget = 12 * n + 100;
      bit stalled = 0;
      logic [31:0] sd;
      logic sl;
      while (got < n && budget > 0) begin
         @(negedge clock);
         budget--;
         if (stalled) begin
            check("stall_valid", {31'b0, m_axis_tvalid}, 32'd1);
            check("stall_data", m_axis_tdata, sd);
            check("stall_last", {31'b0, m_axis_tlast}, {31'b0, sl});
         end
         m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
         stalled = 0;
         if (m_axis_tvalid) begin
            if (m_axis_tready) begin
               check("out_data", m_axis_tdata, exp_q[got]);
               check("out_last", {31'b0, m_axis_tlast}, {31'b0, (got == n - 1)});
               got++;
            end else begin
               stalled = 1;
               sd = m_axis_tdata;
               sl = m_axis_tlast;
            end
         end
      end
      check("word_count", 32'(got), 32'(n));
      @(negedge clock);
      m_axis_tready = 1'b1;
      check("busy_fall", {31'b0, busy}, 32'd0);
      repeat (4) @(negedge clock);
      check("no_extra", {31'b0, m_axis_tvalid}, 32'd0);
   endtask

   initial begin
      int w1;
      int w2;
      reset = 1'b1;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      mergedFifoRdData = '0;
      repeat (3) @(negedge clock);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_tready", {31'b0, s_axis_tready}, 32'd1);
      check("rst_start", {31'b0, start}, 32'd0);
      check("rst_rden", {31'b0, mergedFifoRdEn}, 32'd0);
      check("rst_wr", {30'b0, fifo1WrEn, fifo2WrEn}, 32'd0);
      check("rst_mvalid", {31'b0, m_axis_tvalid}, 32'd0);
      check("rst_mlast", {31'b0, m_axis_tlast}, 32'd0);
      check("rst_ovf", {31'b0, overflow}, 32'd0);
      reset = 1'b0;

      // Basic merge, with input driven while the merge is pending.
      in_q = '{32'd1, 32'd4, 32'd9};  send_q();
      in_q = '{32'd2, 32'd3, 32'd10}; send_q();
      wait_start();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("merge_tready", {31'b0, s_axis_tready}, 32'd0);
         check("merge_wr", {30'b0, fifo1WrEn, fifo2WrEn}, 32'd0);
      end
      s_axis_tvalid = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         check("start_held", {31'b0, start}, 32'd1);
         @(negedge clock);
      end
      check("done_seen", {31'b0, done}, 32'd1);
      check("start_at_done", {31'b0, start}, 32'd1);
      @(negedge clock);
      check("start_fall", {31'b0, start}, 32'd0);
      exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd9, 32'd10};
      collect(0);
      check("wr1_count", 32'(wr1_cnt), 32'd3);
      check("wr2_count", 32'(wr2_cnt), 32'd3);

      // One-word lists.
      in_q = '{32'd5}; send_q();
      in_q = '{32'd7}; send_q();
      exp_q = '{32'd5, 32'd7};
      collect(0);

      // Back-pressure on the output.
      in_q = '{32'd20, 32'd30, 32'd40}; send_q();
      in_q = '{32'd10, 32'd25, 32'd50}; send_q();
      exp_q = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd40, 32'd50};
      m_axis_tready = 1'b0;
      collect(1);

      // List A one word too long.
      w1 = wr1_cnt;
      w2 = wr2_cnt;
      in_q.delete();
      for (int i = 0; i <= DEPTH; i++) in_q.push_back(32'(i));
      send_q();
      check("ovf_set", {31'b0, overflow}, 32'd1);
      in_q = '{32'hFFFF_FFFF}; send_q();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'(i));
      exp_q.push_back(32'hFFFF_FFFF);
      collect(0);
      check("ovf_wr1", 32'(wr1_cnt - w1), 32'(DEPTH));
      check("ovf_wr2", 32'(wr2_cnt - w2), 32'd1);
      check("ovf_sticky", {31'b0, overflow}, 32'd1);

      // Reset while merging, then a fresh merge.
      in_q = '{32'd7, 32'd8}; send_q();
      in_q = '{32'd6};        send_q();
      wait_start();
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("abort_start_now", {31'b0, start}, 32'd0);
      @(negedge clock);
      check("abort_start", {31'b0, start}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_ovf", {31'b0, overflow}, 32'd0);
      check("abort_rden", {31'b0, mergedFifoRdEn}, 32'd0);
      reset = 1'b0;
      in_q = '{32'd3};        send_q();
      in_q = '{32'd1, 32'd2}; send_q();
      exp_q = '{32'd1, 32'd2, 32'd3};
      collect(0);

      check("rd_underflow", 32'(rd_underflow), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
